// File: rtl/register_file_pkg.sv
// Shared constants and types for the processor register file.
// The PC slot sits at the top address and has no storage behind it.
package register_file_pkg;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 3;
    localparam int PC_IDX     = 7;
    localparam int NUM_REGS   = 2 ** ADDR_W;
    localparam int NUM_STORED = PC_IDX;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/register_file_reg_en.sv
// Single data register with a load enable and an asynchronous active-low clear.
module reg_en
    import register_file_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    word_t data_q;
    word_t data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/register_file.sv
// 8 x 8-bit register file: two combinational read ports, one synchronous write port.
// Address PC_IDX reads the externally supplied R7 value and ignores writes.
module register_file
    import register_file_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic              WE3,
    input  logic [DATA_W-1:0] WD3,
    input  logic [DATA_W-1:0] R7,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] tbout1,
    output logic [DATA_W-1:0] tbout2,
    output logic [DATA_W-1:0] tbout6
);

    logic [NUM_STORED-1:0] writeEn;
    word_t                 regVal  [NUM_STORED];
    word_t                 readSrc [NUM_REGS];

    // Write decoder: only stored registers get an enable, so address PC_IDX has no effect.
    always_comb begin
        writeEn = '0;
        for (int i = 0; i < NUM_STORED; i++) begin
            writeEn[i] = WE3 && (A3 == ADDR_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_STORED; g++) begin : gRegs
        reg_en uReg (
            .clk_i (clk),
            .rst_ni(reset),
            .en_i  (writeEn[g]),
            .d_i   (WD3),
            .q_o   (regVal[g])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_STORED; i++) begin
            readSrc[i] = regVal[i];
        end
        readSrc[PC_IDX] = R7;
    end

    assign RD1    = readSrc[A1];
    assign RD2    = readSrc[A2];
    assign tbout1 = regVal[1];
    assign tbout2 = regVal[2];
    assign tbout6 = regVal[6];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus queues expected values, a monitor process compares them.
module tb_register_file;

    logic       clk;
    logic       reset;
    logic [2:0] A1, A2, A3;
    logic       WE3;
    logic [7:0] WD3, R7;
    logic [7:0] RD1, RD2, tbout1, tbout2, tbout6;

    register_file dut (
        .clk   (clk),
        .reset (reset),
        .A1    (A1),
        .A2    (A2),
        .A3    (A3),
        .WE3   (WE3),
        .WD3   (WD3),
        .R7    (R7),
        .RD1   (RD1),
        .RD2   (RD2),
        .tbout1(tbout1),
        .tbout2(tbout2),
        .tbout6(tbout6)
    );

    typedef enum int {SEL_RD1, SEL_RD2, SEL_TB1, SEL_TB2, SEL_TB6} sel_e;

    typedef struct {
        string      name;
        sel_e       sel;
        logic [7:0] exp;
    } check_t;

    check_t expQ[$];
    logic   sampleReq;
    int     vectors;
    int     miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: whenever the stimulus side asks for a sample, drain and compare every pending expectation.
    initial begin
        check_t     item;
        logic [7:0] actual;
        forever begin
            @(sampleReq);
            while (expQ.size() > 0) begin
                item = expQ.pop_front();
                case (item.sel)
                    SEL_RD1: actual = RD1;
                    SEL_RD2: actual = RD2;
                    SEL_TB1: actual = tbout1;
                    SEL_TB2: actual = tbout2;
                    default: actual = tbout6;
                endcase
                vectors++;
                if (actual !== item.exp) begin
                    miscompares++;
                    $display("[TB] FAIL %s: got %h, expected %h", item.name, actual, item.exp);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input sel_e sel, input logic [7:0] exp);
        check_t item;
        item.name = name;
        item.sel  = sel;
        item.exp  = exp;
        expQ.push_back(item);
    endtask

    task automatic flushChecks();
        #1;
        sampleReq = ~sampleReq;
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] data, input logic we);
        @(negedge clk);
        WE3 = we;
        A3  = addr;
        WD3 = data;
        @(posedge clk);
        #1;
        WE3 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] expVal;
        vectors     = 0;
        miscompares = 0;
        sampleReq   = 1'b0;
        reset       = 1'b0;
        A1 = 3'd0; A2 = 3'd7; A3 = 3'd0;
        WE3 = 1'b0; WD3 = 8'h00; R7 = 8'h99;

        // Reset state
        @(negedge clk);
        checkOutput("rst_tb1", SEL_TB1, 8'h00);
        checkOutput("rst_tb2", SEL_TB2, 8'h00);
        checkOutput("rst_tb6", SEL_TB6, 8'h00);
        checkOutput("rst_rd1_r0", SEL_RD1, 8'h00);
        checkOutput("rst_rd2_r7", SEL_RD2, 8'h99);
        flushChecks();
        @(negedge clk);
        reset = 1'b1;

        // Async reset mid-cycle, and writes blocked while held
        applyStimulus(3'd1, 8'h11, 1'b1);
        applyStimulus(3'd6, 8'h66, 1'b1);
        checkOutput("pre_tb1", SEL_TB1, 8'h11);
        checkOutput("pre_tb6", SEL_TB6, 8'h66);
        flushChecks();
        @(negedge clk);
        A1    = 3'd1;
        reset = 1'b0;
        WE3 = 1'b1; A3 = 3'd1; WD3 = 8'h77;
        checkOutput("async_tb1", SEL_TB1, 8'h00);
        checkOutput("async_tb6", SEL_TB6, 8'h00);
        checkOutput("async_rd1", SEL_RD1, 8'h00);
        flushChecks();
        @(posedge clk);
        checkOutput("blocked_tb1", SEL_TB1, 8'h00);
        flushChecks();
        WE3 = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Write then read on both ports
        applyStimulus(3'd2, 8'hA5, 1'b1);
        A1 = 3'd2; A2 = 3'd2;
        checkOutput("wr_tb2", SEL_TB2, 8'hA5);
        checkOutput("wr_rd1", SEL_RD1, 8'hA5);
        checkOutput("wr_rd2", SEL_RD2, 8'hA5);
        flushChecks();

        // WE3 low leaves the register alone
        applyStimulus(3'd1, 8'h42, 1'b1);
        applyStimulus(3'd1, 8'hFF, 1'b0);
        checkOutput("we0_tb1", SEL_TB1, 8'h42);
        flushChecks();

        // R7 mapping, live propagation, and ignored write to address 7
        @(negedge clk);
        A1 = 3'd7; R7 = 8'h3C;
        checkOutput("r7_rd1", SEL_RD1, 8'h3C);
        flushChecks();
        R7 = 8'hC3;
        checkOutput("r7_live", SEL_RD1, 8'hC3);
        flushChecks();
        applyStimulus(3'd7, 8'h00, 1'b1);
        checkOutput("r7_wr00", SEL_RD1, 8'hC3);
        flushChecks();
        applyStimulus(3'd7, 8'hEE, 1'b1);
        A2 = 3'd0;
        checkOutput("r7_wrEE", SEL_RD1, 8'hC3);
        checkOutput("r7_r0", SEL_RD2, 8'h00);
        checkOutput("r7_tb1", SEL_TB1, 8'h42);
        checkOutput("r7_tb2", SEL_TB2, 8'hA5);
        checkOutput("r7_tb6", SEL_TB6, 8'h00);
        flushChecks();

        // Read-during-write: old value until the edge, new after
        @(negedge clk);
        A1 = 3'd6; A3 = 3'd6; WE3 = 1'b1; WD3 = 8'h5A;
        checkOutput("rdw_before", SEL_RD1, 8'h00);
        flushChecks();
        @(posedge clk);
        checkOutput("rdw_after", SEL_RD1, 8'h5A);
        checkOutput("rdw_tb6", SEL_TB6, 8'h5A);
        flushChecks();
        WE3 = 1'b0;

        // Sweep all addresses on both ports
        for (int i = 0; i < 7; i++) begin
            applyStimulus(3'(i), 8'h10 + 8'(i), 1'b1);
        end
        @(negedge clk);
        R7 = 8'h77;
        for (int a = 0; a < 8; a++) begin
            A1 = 3'(a);
            A2 = 3'(7 - a);
            expVal = (a == 7) ? 8'h77 : 8'h10 + 8'(a);
            checkOutput($sformatf("sweep_rd1_%0d", a), SEL_RD1, expVal);
            expVal = (a == 0) ? 8'h77 : 8'h10 + 8'(7 - a);
            checkOutput($sformatf("sweep_rd2_%0d", 7 - a), SEL_RD2, expVal);
            flushChecks();
        end

        for (int i = 0; i < 100 && expQ.size() != 0; i++) begin
            #1;
        end
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: pending %0d, expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
